spi_txn_arbiter: RTL and testbench
==================================

Name: spi_txn_arbiter

Overview:
- Arbitrates up to NUM_REQ on-board requesters for a single SPI master port using round-robin arbitration.
- Sequences each transaction onto that port: command byte, 16-bit address, 32-bit write data, run/done handshake.
- Returns read data or a timeout error to the winning requester.
- Sits between the register-access clients (tester sequencer, config loader, status poller) and the SPI master.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- RD_COM, 8'h0F, command code that denotes a read; every other code is a write.
- TIMEOUT_CYCLES, 4096, mclk cycles allowed from spi_run rise to spi_done rise.
- GAP_CYCLES, 8, idle mclk cycles enforced between consecutive transactions (cs_n deassert time).

Ports:
- mclk  in  1  controller clock; all I/O synchronous to it.
- rst_n  in  1  synchronous, active-low reset.
- req  in  NUM_REQ  per-requester request level.
- req_com  in  8*NUM_REQ  packed command bytes; requester i occupies [8i+7:8i].
- req_addr  in  16*NUM_REQ  packed addresses.
- req_wdata  in  32*NUM_REQ  packed write data.
- ack  out  NUM_REQ  one-cycle completion pulse to the granted requester.
- rsp_err  out  1  valid with ack; 1 = timeout.
- rsp_rdata  out  32  valid with ack; captured MISO word for reads, 0 for writes or on error.
- busy  out  1  high in every state except IDLE.
- grant_id  out  3  index of the current or last granted requester.
- spi_run  out  1  start request to the SPI master.
- spi_com  out  8  command to the SPI master.
- spi_addr  out  16  address to the SPI master.
- mosi_data  out  32  write data to the SPI master.
- miso_data  in  32  read shift register from the SPI master.
- spi_done  in  1  end-of-transfer pulse from the SPI master (one or more cycles high).

Behaviour:
- Reset values: all outputs 0; spi_com resets to 8'h00; round-robin pointer = 0; state = IDLE.
- Reset mid-transaction drops spi_run on the next edge; no ack is issued.
- States: IDLE -> LAUNCH -> WAIT_DONE -> WAIT_END -> RESP -> GAP -> IDLE. TIMEOUT is an alternative exit from WAIT_DONE.
- IDLE:
  - If req != 0, pick the first set bit searching from pointer upward, with wrap-around.
  - Register that requester's com/addr/wdata onto spi_com/spi_addr/mosi_data and set grant_id.
  - Advance pointer to grant+1 mod NUM_REQ; go to LAUNCH.
  - Grant decision takes exactly 1 cycle after req is seen.
- LAUNCH:
  - spi_run = 1; clear timeout counter; go to WAIT_DONE.
  - Command, address and data outputs stay frozen until RESP.
- WAIT_DONE:
  - Hold spi_run = 1 and increment the timeout counter.
  - On a spi_done rising edge (registered previous value = 0, current = 1): spi_run = 0, go to WAIT_END.
  - If the counter reaches TIMEOUT_CYCLES-1 first: spi_run = 0, go to TIMEOUT.
  - If a done edge and the timeout terminal count fall in the same cycle, done wins.
- WAIT_END:
  - On the spi_done falling edge, latch rsp_rdata = miso_data when spi_com == RD_COM, else 0.
  - rsp_err = 0; go to RESP.
  - No timeout applies in this state.
- TIMEOUT: rsp_rdata = 0, rsp_err = 1; go to RESP.
- RESP:
  - ack[grant_id] = 1 for exactly one cycle; rsp_rdata and rsp_err hold until the next RESP.
  - Go to GAP and load the gap counter.
- GAP:
  - Count GAP_CYCLES cycles, then go to IDLE.
  - req is ignored during GAP, so a requester can drop req after ack without being regranted.
- Requester rules:
  - Hold req and all fields stable until ack.
  - Deasserting req before ack is illegal; the transaction still completes and ack is still issued.
- Fairness: with all requesters asserting, grants cycle 0,1,2,3,0,… with no starvation.
- A spi_done pulse arriving outside WAIT_DONE/WAIT_END is ignored.

Decomposition:
- Shared package spi_pkg holds:
  - constants SPI_RD_COM = 8'h0F, SPI_COM_W = 8, SPI_ADDR_W = 16, SPI_DATA_W = 32;
  - the state encoding localparams;
  - function rr_pick(req, ptr).
- One sub-module, spi_rr_arbiter: purely combinational round-robin priority pick returning a one-hot grant plus an index. Pointer update and FSM stay in the top level.

Test Plan:
- Single write: req[1] with com=8'h02, addr=16'h0010, wdata=32'hA5A5_5A5A; model pulses spi_done after 60 cycles -> spi_run high from cycle 2 until the done edge, outputs match the request, ack[1] pulses once, rsp_err=0, rsp_rdata=0.
- Single read: req[2] with com=8'h0F, addr=16'h0004; model presents miso_data=32'hDEAD_BEEF when done falls -> ack[2] with rsp_rdata=32'hDEAD_BEEF.
- Round-robin: req=4'b1111 held, re-raised after each ack -> grant order 0,1,2,3,0,1; at least GAP_CYCLES=8 idle cycles between spi_run pulses.
- Timeout: model never asserts spi_done -> spi_run drops after 4096 cycles, ack pulses with rsp_err=1 and rsp_rdata=0, next request is served normally.
- Done at timeout boundary: spi_done rises on cycle 4095 of WAIT_DONE -> rsp_err=0, rdata captured.
- Reset mid-transaction: rst_n low while in WAIT_DONE -> the next edge shows all outputs 0, no ack, pointer 0; the following request to req[3] is granted normally.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types, constants and the round-robin pick function for the SPI transaction arbiter.
package spi_pkg;

    localparam logic [7:0] SPI_RD_COM  = 8'h0F;
    localparam int         SPI_COM_W   = 8;
    localparam int         SPI_ADDR_W  = 16;
    localparam int         SPI_DATA_W  = 32;
    localparam int         SPI_MAX_REQ = 8;
    localparam int         SPI_ID_W    = 3;
    localparam int         SPI_STATE_W = 3;

    typedef enum logic [SPI_STATE_W-1:0] {
        ST_IDLE      = 3'd0,
        ST_LAUNCH    = 3'd1,
        ST_WAIT_DONE = 3'd2,
        ST_WAIT_END  = 3'd3,
        ST_TIMEOUT   = 3'd4,
        ST_RESP      = 3'd5,
        ST_GAP       = 3'd6
    } spi_state_e;

    // Returns {found, index}: first set bit of req at or above ptr, wrapping at num_req.
    function automatic logic [SPI_ID_W:0] rr_pick(
        input logic [SPI_MAX_REQ-1:0] req,
        input logic [SPI_ID_W-1:0]    ptr,
        input int                     num_req
    );
        logic [SPI_ID_W:0]   pick;
        logic [SPI_ID_W-1:0] slot;
        pick = '0;
        // Scan farthest-first so the slot closest to ptr overwrites the others.
        for (int k = SPI_MAX_REQ - 1; k >= 0; k--) begin
            if (k < num_req) begin
                slot = SPI_ID_W'((int'(ptr) + k) % num_req);
                if (req[slot]) begin
                    pick = {1'b1, slot};
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/spi_rr_arbiter.sv
// Combinational round-robin pick: one-hot grant plus index, starting the search at ptr.
module spi_rr_arbiter
    import spi_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]  req,
    input  logic [SPI_ID_W-1:0] ptr,
    output logic                gnt_valid,
    output logic [SPI_ID_W-1:0] gnt_idx,
    output logic [NUM_REQ-1:0]  gnt_onehot
);

    logic [SPI_ID_W:0] pick;

    always_comb begin
        pick       = rr_pick(SPI_MAX_REQ'(req), ptr, NUM_REQ);
        gnt_valid  = pick[SPI_ID_W];
        gnt_idx    = pick[SPI_ID_W-1:0];
        gnt_onehot = gnt_valid ? (NUM_REQ'(1) << gnt_idx) : '0;
    end

endmodule

// File: rtl/spi_txn_arbiter.sv
// Round-robin arbiter that sequences one register transaction at a time onto a shared SPI master
// and returns read data or a timeout error to the granted requester.
module spi_txn_arbiter
    import spi_pkg::*;
#(
    parameter int         NUM_REQ        = 4,
    parameter logic [7:0] RD_COM         = SPI_RD_COM,
    parameter int         TIMEOUT_CYCLES = 4096,
    parameter int         GAP_CYCLES     = 8
) (
    input  logic                          mclk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [SPI_COM_W*NUM_REQ-1:0]  req_com,
    input  logic [SPI_ADDR_W*NUM_REQ-1:0] req_addr,
    input  logic [SPI_DATA_W*NUM_REQ-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            ack,
    output logic                          rsp_err,
    output logic [SPI_DATA_W-1:0]         rsp_rdata,
    output logic                          busy,
    output logic [SPI_ID_W-1:0]           grant_id,
    output logic                          spi_run,
    output logic [SPI_COM_W-1:0]          spi_com,
    output logic [SPI_ADDR_W-1:0]         spi_addr,
    output logic [SPI_DATA_W-1:0]         mosi_data,
    input  logic [SPI_DATA_W-1:0]         miso_data,
    input  logic                          spi_done
);

    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES - 1);

    spi_state_e            state_q, state_d;
    logic [SPI_ID_W-1:0]   ptr_q, ptr_d;
    logic [SPI_ID_W-1:0]   grant_id_q, grant_id_d;
    logic [NUM_REQ-1:0]    gnt_oh_q, gnt_oh_d;
    logic [NUM_REQ-1:0]    ack_q, ack_d;
    logic                  spi_run_q, spi_run_d;
    logic [SPI_COM_W-1:0]  spi_com_q, spi_com_d;
    logic [SPI_ADDR_W-1:0] spi_addr_q, spi_addr_d;
    logic [SPI_DATA_W-1:0] mosi_data_q, mosi_data_d;
    logic                  rsp_err_q, rsp_err_d;
    logic [SPI_DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  busy_q, busy_d;
    logic                  done_prev_q;
    logic [TO_W-1:0]       to_cnt_q, to_cnt_d;
    logic [GAP_W-1:0]      gap_cnt_q, gap_cnt_d;

    logic                  pick_valid;
    logic [SPI_ID_W-1:0]   pick_idx;
    logic [NUM_REQ-1:0]    pick_oh;
    logic [SPI_COM_W-1:0]  sel_com;
    logic [SPI_ADDR_W-1:0] sel_addr;
    logic [SPI_DATA_W-1:0] sel_wdata;
    logic                  done_rise;
    logic                  done_fall;

    spi_rr_arbiter #(
        .NUM_REQ    (NUM_REQ)
    ) u_rr (
        .req        (req),
        .ptr        (ptr_q),
        .gnt_valid  (pick_valid),
        .gnt_idx    (pick_idx),
        .gnt_onehot (pick_oh)
    );

    assign done_rise = spi_done & ~done_prev_q;
    assign done_fall = ~spi_done & done_prev_q;

    // Field mux with constant slice bounds per requester.
    always_comb begin
        sel_com   = '0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_idx == SPI_ID_W'(i)) begin
                sel_com   = req_com[i*SPI_COM_W +: SPI_COM_W];
                sel_addr  = req_addr[i*SPI_ADDR_W +: SPI_ADDR_W];
                sel_wdata = req_wdata[i*SPI_DATA_W +: SPI_DATA_W];
            end
        end
    end

    always_comb begin
        // NOTE: every _d defaults to its _q (or idle value) first, so no path infers a latch.
        state_d     = state_q;
        ptr_d       = ptr_q;
        grant_id_d  = grant_id_q;
        gnt_oh_d    = gnt_oh_q;
        ack_d       = '0;
        spi_run_d   = spi_run_q;
        spi_com_d   = spi_com_q;
        spi_addr_d  = spi_addr_q;
        mosi_data_d = mosi_data_q;
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;
        to_cnt_d    = to_cnt_q;
        gap_cnt_d   = gap_cnt_q;

        unique case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    grant_id_d  = pick_idx;
                    gnt_oh_d    = pick_oh;
                    spi_com_d   = sel_com;
                    spi_addr_d  = sel_addr;
                    mosi_data_d = sel_wdata;
                    ptr_d       = (pick_idx == SPI_ID_W'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
                    state_d     = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                spi_run_d = 1'b1;
                to_cnt_d  = '0;
                state_d   = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                // A done edge on the terminal-count cycle still counts as success.
                if (done_rise) begin
                    spi_run_d = 1'b0;
                    state_d   = ST_WAIT_END;
                end else if (to_cnt_q == TO_LAST) begin
                    spi_run_d = 1'b0;
                    state_d   = ST_TIMEOUT;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            ST_WAIT_END: begin
                if (done_fall) begin
                    rsp_rdata_d = (spi_com_q == RD_COM) ? miso_data : '0;
                    rsp_err_d   = 1'b0;
                    ack_d       = gnt_oh_q;
                    state_d     = ST_RESP;
                end
            end
            ST_TIMEOUT: begin
                rsp_rdata_d = '0;
                rsp_err_d   = 1'b1;
                ack_d       = gnt_oh_q;
                state_d     = ST_RESP;
            end
            ST_RESP: begin
                gap_cnt_d = GAP_LOAD;
                state_d   = ST_GAP;
            end
            ST_GAP: begin
                if (gap_cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge mclk) begin
        // NOTE: flops use <= so every register in this block samples pre-edge values.
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            grant_id_q  <= '0;
            gnt_oh_q    <= '0;
            ack_q       <= '0;
            spi_run_q   <= 1'b0;
            spi_com_q   <= 8'h00;
            spi_addr_q  <= '0;
            mosi_data_q <= '0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            busy_q      <= 1'b0;
            done_prev_q <= 1'b0;
            to_cnt_q    <= '0;
            gap_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            grant_id_q  <= grant_id_d;
            gnt_oh_q    <= gnt_oh_d;
            ack_q       <= ack_d;
            spi_run_q   <= spi_run_d;
            spi_com_q   <= spi_com_d;
            spi_addr_q  <= spi_addr_d;
            mosi_data_q <= mosi_data_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
            busy_q      <= busy_d;
            done_prev_q <= spi_done;
            to_cnt_q    <= to_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
        end
    end

    assign ack       = ack_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;
    assign busy      = busy_q;
    assign grant_id  = grant_id_q;
    assign spi_run   = spi_run_q;
    assign spi_com   = spi_com_q;
    assign spi_addr  = spi_addr_q;
    assign mosi_data = mosi_data_q;

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// Directed bench: scoreboard of expected responses, SPI master model, and launch/ack monitors.
module tb_spi_txn_arbiter;

    localparam int NUM_REQ = 4;
    localparam int GAP     = 8;

    typedef struct {
        int          id;
        logic [7:0]  com;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    logic                    mclk = 1'b0;
    logic                    rst_n;
    logic [NUM_REQ-1:0]      req;
    logic [8*NUM_REQ-1:0]    req_com;
    logic [16*NUM_REQ-1:0]   req_addr;
    logic [32*NUM_REQ-1:0]   req_wdata;
    logic [NUM_REQ-1:0]      ack;
    logic                    rsp_err;
    logic [31:0]             rsp_rdata;
    logic                    busy;
    logic [2:0]              grant_id;
    logic                    spi_run;
    logic [7:0]              spi_com;
    logic [15:0]             spi_addr;
    logic [31:0]             mosi_data;
    logic [31:0]             miso_data;
    logic                    spi_done;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          model_delay;
    bit          model_never;
    logic [31:0] model_miso;
    bit          gap_chk_en;
    int          last_run_len = 0;

    spi_txn_arbiter #(
        .NUM_REQ        (NUM_REQ),
        .RD_COM         (8'h0F),
        .TIMEOUT_CYCLES (4096),
        .GAP_CYCLES     (GAP)
    ) dut (
        .mclk      (mclk),
        .rst_n     (rst_n),
        .req       (req),
        .req_com   (req_com),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .ack       (ack),
        .rsp_err   (rsp_err),
        .rsp_rdata (rsp_rdata),
        .busy      (busy),
        .grant_id  (grant_id),
        .spi_run   (spi_run),
        .spi_com   (spi_com),
        .spi_addr  (spi_addr),
        .mosi_data (mosi_data),
        .miso_data (miso_data),
        .spi_done  (spi_done)
    );

    always #5 mclk = ~mclk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input int id, input logic [7:0] c, input logic [15:0] a,
                            input logic [31:0] w, input logic e, input logic [31:0] r);
        req_com[8*id +: 8]    = c;
        req_addr[16*id +: 16] = a;
        req_wdata[32*id +: 32] = w;
        sb.push_back('{id, c, a, w, e, r});
    endtask

    task automatic wait_ack(input int budget);
        int n;
        n = 0;
        do begin
            @(negedge mclk);
            n++;
        end while (ack == '0 && n < budget);
        check("ack_within_budget", 64'(ack != '0), 64'd1);
    endtask

    task automatic check_all_zero(input string pfx);
        check({pfx, "_ack"},       64'(ack),       64'd0);
        check({pfx, "_busy"},      64'(busy),      64'd0);
        check({pfx, "_spi_run"},   64'(spi_run),   64'd0);
        check({pfx, "_spi_com"},   64'(spi_com),   64'd0);
        check({pfx, "_spi_addr"},  64'(spi_addr),  64'd0);
        check({pfx, "_mosi_data"}, 64'(mosi_data), 64'd0);
        check({pfx, "_grant_id"},  64'(grant_id),  64'd0);
        check({pfx, "_rsp_err"},   64'(rsp_err),   64'd0);
        check({pfx, "_rsp_rdata"}, 64'(rsp_rdata), 64'd0);
    endtask

    // SPI master model plus launch/ack monitors, all sampled on the falling edge.
    initial begin
        exp_t e;
        bit   run_prev;
        int   run_len;
        int   low_len;
        int   mcnt;
        run_prev  = 1'b0;
        run_len   = 0;
        low_len   = 0;
        mcnt      = 0;
        spi_done  = 1'b0;
        miso_data = '0;
        forever begin
            @(negedge mclk);
            if (!rst_n) begin
                run_prev = 1'b0;
                run_len  = 0;
                low_len  = 0;
                mcnt     = 0;
                spi_done = 1'b0;
            end else begin
                if (ack != '0) begin
                    check("ack_expected", 64'(sb.size() != 0), 64'd1);
                    if (sb.size() != 0) begin
                        e = sb.pop_front();
                        check("ack_onehot",   64'(ack),       64'd1 << e.id);
                        check("ack_grant_id", 64'(grant_id),  64'(e.id));
                        check("rsp_err",      64'(rsp_err),   64'(e.err));
                        check("rsp_rdata",    64'(rsp_rdata), 64'(e.rdata));
                    end
                end
                if (spi_run && !run_prev) begin
                    if (gap_chk_en) check("gap_at_least_8", 64'(low_len >= GAP), 64'd1);
                    check("launch_expected", 64'(sb.size() != 0), 64'd1);
                    if (sb.size() != 0) begin
                        check("launch_com",   64'(spi_com),   64'(sb[0].com));
                        check("launch_addr",  64'(spi_addr),  64'(sb[0].addr));
                        check("launch_wdata", 64'(mosi_data), 64'(sb[0].wdata));
                    end
                end
                if (spi_run) begin
                    if (!run_prev) run_len = 0;
                    run_len++;
                end else begin
                    if (run_prev) begin
                        last_run_len = run_len;
                        low_len = 0;
                    end
                    low_len++;
                end
                spi_done = 1'b0;
                if (spi_run) begin
                    mcnt++;
                    if (!model_never && mcnt == model_delay) begin
                        spi_done  = 1'b1;
                        miso_data = model_miso;
                    end
                end else begin
                    mcnt = 0;
                end
                run_prev = spi_run;
            end
        end
    end

    initial begin
        int n;
        rst_n       = 1'b0;
        req         = '0;
        req_com     = '0;
        req_addr    = '0;
        req_wdata   = '0;
        model_delay = 1000;
        model_never = 1'b0;
        model_miso  = '0;
        gap_chk_en  = 1'b0;
        repeat (3) @(negedge mclk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge mclk);

        // Single write to requester 1
        model_delay = 60;
        push_exp(1, 8'h02, 16'h0010, 32'hA5A5_5A5A, 1'b0, 32'h0);
        req = 4'b0010;
        @(negedge mclk);
        check("wr_grant_id_c1", 64'(grant_id), 64'd1);
        check("wr_busy_c1",     64'(busy),     64'd1);
        check("wr_run_low_c1",  64'(spi_run),  64'd0);
        @(negedge mclk);
        check("wr_run_high_c2", 64'(spi_run),  64'd1);
        wait_ack(200);
        req = '0;
        check("wr_run_len", 64'(last_run_len), 64'd60);

        // Single read from requester 2
        model_delay = 20;
        model_miso  = 32'hDEAD_BEEF;
        push_exp(2, 8'h0F, 16'h0004, 32'h0, 1'b0, 32'hDEAD_BEEF);
        req = 4'b0100;
        wait_ack(200);
        req = '0;

        // Timeout: master never answers; read data must still come back as 0
        model_never = 1'b1;
        model_miso  = 32'hCAFE_F00D;
        push_exp(0, 8'h0F, 16'h0040, 32'h0, 1'b1, 32'h0);
        req = 4'b0001;
        wait_ack(4200);
        req = '0;
        check("to_run_len", 64'(last_run_len), 64'd4096);

        // Normal write right after a timeout
        model_never = 1'b0;
        model_delay = 10;
        push_exp(3, 8'h03, 16'h0030, 32'h1122_3344, 1'b0, 32'h0);
        req = 4'b1000;
        wait_ack(200);
        req = '0;

        // Done edge on the last WAIT_DONE cycle beats the timeout
        model_delay = 4096;
        model_miso  = 32'h1234_5678;
        push_exp(0, 8'h0F, 16'h0044, 32'h0, 1'b0, 32'h1234_5678);
        req = 4'b0001;
        wait_ack(4200);
        req = '0;
        check("bnd_run_len", 64'(last_run_len), 64'd4096);

        // Reset in WAIT_DONE after granting requester 2 (pointer would be 3)
        model_delay = 1000;
        push_exp(2, 8'h0F, 16'h0008, 32'h0, 1'b0, 32'h0);
        req = 4'b0100;
        n = 0;
        while (!spi_run && n < 50) begin
            @(negedge mclk);
            n++;
        end
        check("midrst_launched", 64'(spi_run), 64'd1);
        repeat (10) @(negedge mclk);
        rst_n = 1'b0;
        req   = '0;
        sb.delete();
        @(negedge mclk);
        check_all_zero("midrst");
        rst_n = 1'b1;
        @(negedge mclk);

        // Pointer back at 0: requester 1 beats requester 3
        model_delay = 8;
        push_exp(1, 8'h05, 16'h0101, 32'hAAAA_0001, 1'b0, 32'h0);
        push_exp(3, 8'h06, 16'h0303, 32'hAAAA_0003, 1'b0, 32'h0);
        req = 4'b1010;
        wait_ack(200);
        req[1] = 1'b0;
        wait_ack(200);
        req = '0;

        // Fairness with everyone requesting
        model_delay = 5;
        gap_chk_en  = 1'b1;
        for (int k = 0; k < 6; k++) begin
            push_exp(k % 4, 8'h10 + 8'(k % 4), 16'h0100 + 16'(k % 4), 32'h1000_0000 + 32'(k % 4),
                     1'b0, 32'h0);
        end
        req = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            wait_ack(200);
        end
        req = '0;
        repeat (20) @(negedge mclk);
        check("rr_idle_busy", 64'(busy), 64'd0);
        check("sb_drained",   64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
